// File: rtl/hcsr04_pkg.sv
// Shared definitions for the HC-SR04 trigger/echo emulator and the matching
// measurement (initiator) block.
//   state_e      : responder FSM states
//   CNT_W        : width of all microsecond counters and of the echo length
//   US_PER_CM    : echo microseconds per centimetre of distance
//   MIN_CM/MAX_CM: in-range distance window, inclusive
//   TIMEOUT_US   : echo width reported for out-of-range distances
//   echo_len_us(): distance -> echo length in microseconds
package hcsr04_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrigHi,
    StBurst,
    StEcho,
    StHoldoff
  } state_e;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned US_PER_CM  = 58;
  localparam int unsigned MIN_CM     = 2;
  localparam int unsigned MAX_CM     = 400;
  localparam int unsigned TIMEOUT_US = 38000;

  // Scale and timeout are arguments so reduced-time builds can share the rule.
  function automatic logic [CNT_W-1:0] echo_len_us(input logic [8:0]  cm,
                                                   input int unsigned us_per_cm,
                                                   input int unsigned timeout_us);
    int unsigned cm_u;
    int unsigned len;
    cm_u = 32'(cm);
    if (cm_u >= MIN_CM && cm_u <= MAX_CM) begin
      len = cm_u * us_per_cm;
    end else begin
      len = timeout_us;
    end
    return CNT_W'(len);
  endfunction

endpackage

// File: rtl/hcsr04_echo_emulator_if.sv
// Trigger/echo link between an HC-SR04 initiator and the emulated sensor.
//   trigger     : initiator -> sensor, asynchronous trigger pulse
//   distance_cm : emulated distance, sampled on trigger acceptance
//   enable      : 0 = sensor ignores triggers
//   echo        : sensor -> initiator, width encodes distance
//   busy        : high from trigger acceptance until end of holdoff
//   short_trig  : one-clock pulse when a too-short trigger is rejected
//   done        : one-clock pulse on echo falling edge
// master = initiator / test driver, slave = emulator.
interface hcsr04_echo_emulator_if;

  logic       trigger;
  logic [8:0] distance_cm;
  logic       enable;
  logic       echo;
  logic       busy;
  logic       short_trig;
  logic       done;

  modport master (
    output trigger, distance_cm, enable,
    input  echo, busy, short_trig, done
  );

  modport slave (
    input  trigger, distance_cm, enable,
    output echo, busy, short_trig, done
  );

endinterface

// File: rtl/us_tick_gen.sv
// Free-running microsecond tick: us_tick is high for one clock every
// CLK_PER_US clocks. The divider restarts at 0 on reset.
//   clk     : system clock
//   rst     : asynchronous, active-high reset
//   us_tick : one-clock pulse per microsecond
module us_tick_gen #(
  parameter int unsigned CLK_PER_US = 50
) (
  input  logic clk,
  input  logic rst,
  output logic us_tick
);

  localparam int unsigned CntW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLK_PER_US - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign us_tick = (cnt_q == LastCnt);

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 responder: accepts a trigger pulse of at least TRIG_MIN_US, waits
// BURST_US, drives echo high for a distance-dependent number of microseconds,
// then holds off HOLDOFF_US before accepting the next trigger.
//   clk : system clock
//   rst : asynchronous, active-high reset (echo drops immediately)
//   bus : slave side of hcsr04_echo_emulator_if (trigger/distance_cm/enable in,
//         echo/busy/short_trig/done out)
// ECHO_US_PER_CM / ECHO_TIMEOUT_US default to the package constants; they are
// exposed only so reduced-time builds can shorten the echo.
module hcsr04_echo_emulator
  import hcsr04_pkg::*;
#(
  parameter int unsigned CLK_PER_US      = 50,
  parameter int unsigned TRIG_MIN_US     = 10,
  parameter int unsigned BURST_US        = 200,
  parameter int unsigned HOLDOFF_US      = 10000,
  parameter int unsigned ECHO_US_PER_CM  = US_PER_CM,
  parameter int unsigned ECHO_TIMEOUT_US = TIMEOUT_US
) (
  input  logic                   clk,
  input  logic                   rst,
  hcsr04_echo_emulator_if.slave  bus
);

  localparam logic [CNT_W-1:0] BurstLast   = CNT_W'(BURST_US - 1);
  localparam logic [CNT_W-1:0] HoldoffLast = CNT_W'(HOLDOFF_US - 1);

  logic us_tick;

  us_tick_gen #(
    .CLK_PER_US (CLK_PER_US)
  ) u_us_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .us_tick (us_tick)
  );

  // Trigger synchroniser and edge detect.
  logic trig_meta_q, trig_sync_q, trig_prev_q;
  logic trig_rise, trig_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_meta_q <= 1'b0;
      trig_sync_q <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_meta_q <= bus.trigger;
      trig_sync_q <= trig_meta_q;
      trig_prev_q <= trig_sync_q;
    end
  end

  assign trig_rise = trig_sync_q & ~trig_prev_q;
  assign trig_fall = ~trig_sync_q & trig_prev_q;

  state_e           state_q, state_d;
  logic [7:0]       width_q, width_d;
  logic [7:0]       width_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             echo_q, echo_d;
  logic             busy_q, busy_d;
  logic             short_q, short_d;
  logic             done_q, done_d;

  // A tick coinciding with the fall-detect cycle still counts, so a trigger
  // of N us always measures exactly N ticks whatever the tick phase.
  assign width_inc = (width_q == 8'hFF) ? width_q : width_q + 8'(us_tick);

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    echo_d  = echo_q;
    busy_d  = busy_q;
    short_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (trig_rise && bus.enable) begin
          state_d = StTrigHi;
          width_d = '0;
        end
      end

      StTrigHi: begin
        if (trig_fall) begin
          if (32'(width_inc) >= TRIG_MIN_US) begin
            len_d   = echo_len_us(bus.distance_cm, ECHO_US_PER_CM, ECHO_TIMEOUT_US);
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = StBurst;
          end else begin
            short_d = 1'b1;
            state_d = StIdle;
          end
        end else begin
          width_d = width_inc;
        end
      end

      StBurst: begin
        if (us_tick) begin
          if (cnt_q == BurstLast) begin
            cnt_d   = '0;
            echo_d  = 1'b1;
            state_d = StEcho;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StEcho: begin
        if (us_tick) begin
          if (cnt_q == len_q - 1'b1) begin
            cnt_d   = '0;
            echo_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StHoldoff;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StHoldoff: begin
        if (us_tick) begin
          if (cnt_q == HoldoffLast) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        echo_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      width_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      short_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      echo_q  <= echo_d;
      busy_q  <= busy_d;
      short_q <= short_d;
      done_q  <= done_d;
    end
  end

  assign bus.echo       = echo_q;
  assign bus.busy       = busy_q;
  assign bus.short_trig = short_q;
  assign bus.done       = done_q;

endmodule
